nand_cmd_sequencer: RTL and testbench
=====================================

// Module: nand_cmd_sequencer
// PURPOSE
// - Sequences one complete NAND command transaction over the CLE and ALE latch units:
//   CMD1, 0..5 address cycles, optional CMD2, then optional tWB wait and R/B# wait.
// - Sits between the controller's top-level FSM (req_* handshake) and the two latch units,
//   which it drives through activate/busy.
// - Owns all latch data muxing and reports completion and timeout.
// PARAMETERS
// - T_WB        default 10     cycles waited after the last latch before R/B# is sampled
// - RB_TIMEOUT  default 65535  max cycles in WAIT_RB before abort; 16-bit counter
// - MAX_ADDR    default 5      max address cycles; larger req_addr_cnt is clamped to this
// PORTS
// - clk          in   1   system clock, all logic on rising edge
// - nreset       in   1   asynchronous, active-low reset
// - req_valid    in   1   transaction request
// - req_ready    out  1   sequencer can accept a request this cycle
// - req_cmd1     in   8   first command opcode
// - req_addr     in   40  address bytes; byte0 = [7:0] is issued first
// - req_addr_cnt in   3   number of address cycles, 0..5
// - req_cmd2_en  in   1   issue req_cmd2 after the address cycles
// - req_cmd2     in   8   second command opcode (e.g. 30h)
// - req_wait_rb  in   1   wait tWB, then wait for R/B# high before done
// - done         out  1   one-cycle pulse when the transaction ends
// - timeout      out  1   valid with done; 1 = R/B# did not go high within RB_TIMEOUT
// - cmd_activate out  1   one-cycle activate to the CLE latch unit
// - addr_activate out 1   one-cycle activate to the ALE latch unit
// - latch_data   out  16  data to both latch units; {8'h00, byte}
// - cmd_busy     in   1   busy from the CLE latch unit
// - addr_busy    in   1   busy from the ALE latch unit
// - nand_rb      in   1   R/B# pin, already synchronised; 1 = ready
// BEHAVIOUR
// - Reset values: req_ready=0, done=0, timeout=0, cmd_activate=0, addr_activate=0,
//   latch_data=0. FSM enters IDLE; all counters are cleared.
// - req_ready = (state==IDLE) & !cmd_busy & !addr_busy.
//   - The latch units have no reset, so a reset mid-latch is safe: no new request is
//     accepted until the running latch drains.
// - Request accept: req_valid & req_ready on an edge. All req_* fields are captured in
//   registers, then the FSM goes to CMD1. Later req_* changes are ignored.
// - Main FSM: IDLE -> CMD1 -> ADDR -> CMD2 -> WAIT_WB -> WAIT_RB -> DONE -> IDLE.
//   - ADDR is skipped when cnt=0.
//   - CMD2 is skipped when cmd2_en=0.
//   - WAIT_WB and WAIT_RB are skipped when wait_rb=0.
// - Each latch state runs three phases: ISSUE, ACK, DRAIN.
//   - ISSUE: activate=1 for exactly one cycle, latch_data driven.
//   - ACK: wait for busy==1.
//   - DRAIN: wait for busy==0, then advance.
//   - latch_data holds its value from ISSUE through DRAIN.
// - ADDR loop: a 3-bit index runs 0..cnt-1 and emits req_addr[8*i+:8], one full
//   ISSUE/ACK/DRAIN per byte, so the minimum gap between two activates is 3 cycles.
// - WAIT_WB: counts T_WB cycles and ignores nand_rb; this covers R/B# falling late.
// - WAIT_RB: leaves on nand_rb==1, with timeout=0.
//   - If RB_TIMEOUT cycles pass without nand_rb==1: timeout=1 and the FSM goes to DONE.
//   - If nand_rb==1 on the same cycle the limit is reached, nand_rb wins (timeout=0).
// - DONE: done=1 for one cycle, timeout valid in the same cycle, then IDLE.
//   - done and req_ready are never high in the same cycle.
// - Latency with 0 address cycles, no CMD2 and no R/B# wait: done is asserted
//   (latch duration + 3) cycles after accept.
// - cmd_activate and addr_activate are never high together. Only one latch unit is
//   ever in flight.
// - Asynchronous reset mid-transaction: outputs return to reset values immediately;
//   the transaction is dropped and done is not pulsed.
// STRUCTURE
// - Shared package nand_pkg holds:
//   - latch_t (LATCH_CMD, LATCH_ADDR) and the t_wp, t_wh, t_clh, t_wb constants;
//   - ONFI opcode constants (00h, 30h, 70h, 90h, FFh);
//   - the sequencer state enum seq_state_t.
// - One sub-module: nand_delay_counter (load value, enable, expired flag).
//   It is instantiated once and reused for both WAIT_WB and WAIT_RB.
// TESTING
// - READ PAGE: cmd1=00h, cnt=5, addr=40'h0403020100, cmd2_en=1/30h, wait_rb=1.
//   Expect 1 cmd activate (00), 5 addr activates (00,01,02,03,04) in order,
//   1 cmd activate (30), then done=1 with timeout=0 after nand_rb rises.
// - RESET command: cmd1=FFh, cnt=0, cmd2_en=0, wait_rb=0.
//   Expect exactly one cmd_activate with latch_data=16'h00FF, no addr_activate,
//   and a done pulse.
// - cnt=7: exactly 5 addr activates are issued.
// - Timeout: RB_TIMEOUT=20 with nand_rb held 0.
//   Expect done=1 and timeout=1 exactly T_WB+20 cycles after the last DRAIN.
// - Mid-transaction reset: nreset=0 during the third address cycle, release after 2
//   cycles. Expect req_ready=0 until addr_busy=0; no done pulse; the next request
//   completes normally.
// - Back-to-back: req_valid held high with two requests queued.
//   Expect the second to be accepted only after done; activates never overlap.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared types and constants for the NAND command path: latch selection,
// interface timing, ONFI opcodes and the command sequencer state set.
package nand_pkg;

    typedef enum logic {
        LATCH_CMD,
        LATCH_ADDR
    } latch_t;

    localparam int t_wp  = 2;
    localparam int t_wh  = 2;
    localparam int t_clh = 2;
    localparam int t_wb  = 10;

    localparam logic [7:0] OP_READ         = 8'h00;
    localparam logic [7:0] OP_READ_CONFIRM = 8'h30;
    localparam logic [7:0] OP_READ_STATUS  = 8'h70;
    localparam logic [7:0] OP_READ_ID      = 8'h90;
    localparam logic [7:0] OP_RESET        = 8'hFF;

    localparam int DLY_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_ADDR,
        S_CMD2,
        S_WAIT_WB,
        S_WAIT_RB,
        S_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_ACK,
        PH_DRAIN
    } phase_t;

    function automatic logic [2:0] clamp_addr_cnt(input logic [2:0] cnt, input logic [2:0] max_cnt);
        return (cnt > max_cnt) ? max_cnt : cnt;
    endfunction

endpackage

// File: rtl/nand_delay_counter.sv
// Loadable down-counter; expired flags the last counted cycle so a wait of
// N cycles lasts exactly N cycles after the load edge.
module nand_delay_counter
    import nand_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [DLY_W-1:0] count_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q <= DLY_W'(1));

endmodule

// File: rtl/nand_cmd_sequencer.sv
// Runs one NAND command transaction (CMD1, address bytes, optional CMD2,
// optional tWB + R/B# wait) over the CLE/ALE latch units.
module nand_cmd_sequencer
    import nand_pkg::*;
#(
    parameter int T_WB       = t_wb,
    parameter int RB_TIMEOUT = 65535,
    parameter int MAX_ADDR   = 5
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd1,
    input  logic [39:0] req_addr,
    input  logic [2:0]  req_addr_cnt,
    input  logic        req_cmd2_en,
    input  logic [7:0]  req_cmd2,
    input  logic        req_wait_rb,
    output logic        done,
    output logic        timeout,
    output logic        cmd_activate,
    output logic        addr_activate,
    output logic [15:0] latch_data,
    input  logic        cmd_busy,
    input  logic        addr_busy,
    input  logic        nand_rb
);

    localparam logic [2:0]       MAX_ADDR_W   = 3'(MAX_ADDR);
    localparam logic [DLY_W-1:0] T_WB_W       = DLY_W'(T_WB);
    localparam logic [DLY_W-1:0] RB_TIMEOUT_W = DLY_W'(RB_TIMEOUT);

    seq_state_t state_q, state_d;
    phase_t     phase_q, phase_d;
    seq_state_t after_cmd1, after_addr, after_cmd2;
    latch_t     latch_sel;

    logic        live_q;
    logic [7:0]  cmd1_q, cmd2_q, addr_byte, latch_byte;
    logic [39:0] addr_q;
    logic [2:0]  cnt_q, addr_idx_q;
    logic        cmd2_en_q, wait_rb_q, timeout_q;
    logic        accept, busy_cur, latch_free, last_addr;
    logic        dly_load, dly_en, dly_expired;
    logic [DLY_W-1:0] dly_load_val;

    assign accept     = req_valid && req_ready;
    assign latch_sel  = (state_q == S_ADDR) ? LATCH_ADDR : LATCH_CMD;
    assign busy_cur   = (latch_sel == LATCH_ADDR) ? addr_busy : cmd_busy;
    assign latch_free = (phase_q == PH_DRAIN) && !busy_cur;
    assign last_addr  = (addr_idx_q == cnt_q - 3'd1);

    assign after_cmd2 = wait_rb_q ? S_WAIT_WB : S_DONE;
    assign after_addr = cmd2_en_q ? S_CMD2 : after_cmd2;
    assign after_cmd1 = (cnt_q != 3'd0) ? S_ADDR : after_addr;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            phase_q <= PH_ISSUE;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CMD1;
                    phase_d = PH_ISSUE;
                end
            end
            S_CMD1, S_ADDR, S_CMD2: begin
                case (phase_q)
                    PH_ISSUE: phase_d = PH_ACK;
                    PH_ACK:   if (busy_cur) phase_d = PH_DRAIN;
                    default: begin
                        if (!busy_cur) begin
                            phase_d = PH_ISSUE;
                            if (state_q == S_CMD1)      state_d = after_cmd1;
                            else if (state_q == S_CMD2) state_d = after_cmd2;
                            else if (last_addr)         state_d = after_addr;
                        end
                    end
                endcase
            end
            S_WAIT_WB: if (dly_expired) state_d = S_WAIT_RB;
            // A ready R/B# on the limit cycle still counts as success.
            S_WAIT_RB: if (nand_rb || dly_expired) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            live_q     <= 1'b0;
            cmd1_q     <= '0;
            cmd2_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            cmd2_en_q  <= 1'b0;
            wait_rb_q  <= 1'b0;
            addr_idx_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                cmd1_q     <= req_cmd1;
                cmd2_q     <= req_cmd2;
                addr_q     <= req_addr;
                cnt_q      <= clamp_addr_cnt(req_addr_cnt, MAX_ADDR_W);
                cmd2_en_q  <= req_cmd2_en;
                wait_rb_q  <= req_wait_rb;
                addr_idx_q <= '0;
                timeout_q  <= 1'b0;
            end else if ((state_q == S_ADDR) && latch_free) begin
                addr_idx_q <= addr_idx_q + 3'd1;
            end
            if ((state_q == S_WAIT_RB) && (state_d == S_DONE)) begin
                timeout_q <= !nand_rb;
            end
        end
    end

    // One counter serves both waits: reloaded on entry to each.
    assign dly_load     = ((state_q != S_WAIT_WB) && (state_d == S_WAIT_WB)) ||
                          ((state_q == S_WAIT_WB) && (state_d == S_WAIT_RB));
    assign dly_load_val = (state_q == S_WAIT_WB) ? RB_TIMEOUT_W : T_WB_W;
    assign dly_en       = (state_q == S_WAIT_WB) || (state_q == S_WAIT_RB);

    nand_delay_counter u_delay (
        .clk      (clk),
        .nreset   (nreset),
        .load     (dly_load),
        .load_val (dly_load_val),
        .en       (dly_en),
        .expired  (dly_expired)
    );

    always_comb begin
        case (addr_idx_q)
            3'd0:    addr_byte = addr_q[7:0];
            3'd1:    addr_byte = addr_q[15:8];
            3'd2:    addr_byte = addr_q[23:16];
            3'd3:    addr_byte = addr_q[31:24];
            3'd4:    addr_byte = addr_q[39:32];
            default: addr_byte = 8'h00;
        endcase
    end

    always_comb begin
        req_ready     = live_q && (state_q == S_IDLE) && !cmd_busy && !addr_busy;
        done          = (state_q == S_DONE);
        timeout       = done && timeout_q;
        cmd_activate  = 1'b0;
        addr_activate = 1'b0;
        latch_byte    = 8'h00;
        case (state_q)
            S_CMD1:  latch_byte = cmd1_q;
            S_ADDR:  latch_byte = addr_byte;
            S_CMD2:  latch_byte = cmd2_q;
            default: latch_byte = 8'h00;
        endcase
        if ((phase_q == PH_ISSUE) &&
            ((state_q == S_CMD1) || (state_q == S_ADDR) || (state_q == S_CMD2))) begin
            if (latch_sel == LATCH_ADDR) addr_activate = 1'b1;
            else                         cmd_activate  = 1'b1;
        end
        latch_data = {8'h00, latch_byte};
    end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// Directed bench for nand_cmd_sequencer with behavioural CLE/ALE latch units
// whose busy length is set per step.
module tb_nand_cmd_sequencer;

    localparam int TWB = 10;
    localparam int RBT = 20;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd1 = '0;
    logic [39:0] req_addr = '0;
    logic [2:0]  req_addr_cnt = '0;
    logic        req_cmd2_en = 1'b0;
    logic [7:0]  req_cmd2 = '0;
    logic        req_wait_rb = 1'b0;
    logic        done, timeout, cmd_activate, addr_activate;
    logic [15:0] latch_data;
    logic        cmd_busy, addr_busy;
    logic        nand_rb = 1'b1;

    nand_cmd_sequencer #(.T_WB(TWB), .RB_TIMEOUT(RBT), .MAX_ADDR(5)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd1      (req_cmd1),
        .req_addr      (req_addr),
        .req_addr_cnt  (req_addr_cnt),
        .req_cmd2_en   (req_cmd2_en),
        .req_cmd2      (req_cmd2),
        .req_wait_rb   (req_wait_rb),
        .done          (done),
        .timeout       (timeout),
        .cmd_activate  (cmd_activate),
        .addr_activate (addr_activate),
        .latch_data    (latch_data),
        .cmd_busy      (cmd_busy),
        .addr_busy     (addr_busy),
        .nand_rb       (nand_rb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 2;

    always @(posedge clk) cyc <= cyc + 1;

    // Latch units: no reset; busy for lat cycles starting the cycle after activate.
    logic c_act_s = 1'b0, a_act_s = 1'b0;
    int   c_cnt = 0, a_cnt = 0;
    always @(negedge clk) begin
        c_act_s <= cmd_activate;
        a_act_s <= addr_activate;
    end
    always @(posedge clk) begin
        if (c_act_s) c_cnt <= lat;
        else if (c_cnt != 0) c_cnt <= c_cnt - 1;
        if (a_act_s) a_cnt <= lat;
        else if (a_cnt != 0) a_cnt <= a_cnt - 1;
    end
    assign cmd_busy  = (c_cnt != 0);
    assign addr_busy = (a_cnt != 0);

    bit          act_kind[$];
    logic [15:0] act_data[$];
    int          act_cyc[$];
    int          n_acc = 0, acc_cyc = 0, n_done = 0, done_cyc = 0, viol = 0;
    logic        done_to = 1'b0, prev_done = 1'b0, in_txn = 1'b0;
    logic [15:0] last_data = '0;

    always @(negedge clk) begin
        if (!nreset) begin
            in_txn    <= 1'b0;
            prev_done <= 1'b0;
        end else begin
            if (cmd_activate) begin
                act_kind.push_back(1'b0);
                act_data.push_back(latch_data);
                act_cyc.push_back(cyc);
                last_data <= latch_data;
            end
            if (addr_activate) begin
                act_kind.push_back(1'b1);
                act_data.push_back(latch_data);
                act_cyc.push_back(cyc);
                last_data <= latch_data;
            end
            viol <= viol + int'(cmd_activate && addr_activate)
                         + int'((cmd_activate || addr_activate) && (cmd_busy || addr_busy))
                         + int'(done && req_ready)
                         + int'(done && prev_done)
                         + int'(in_txn && (cmd_busy || addr_busy) && (latch_data !== last_data));
            prev_done <= done;
            if (done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
                done_to  <= timeout;
                in_txn   <= 1'b0;
            end
            if (req_valid && req_ready) begin
                n_acc   <= n_acc + 1;
                acc_cyc <= cyc;
                in_txn  <= 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        act_kind.delete();
        act_data.delete();
        act_cyc.delete();
    endtask

    task automatic do_req(input logic [7:0] c1, input logic [39:0] a, input logic [2:0] n,
                          input logic c2en, input logic [7:0] c2, input logic wrb, input bit hold);
        int base;
        bit ok;
        base = n_acc;
        ok   = 1'b0;
        req_cmd1 = c1; req_addr = a; req_addr_cnt = n;
        req_cmd2_en = c2en; req_cmd2 = c2; req_wait_rb = wrb;
        req_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick(1);
            if (n_acc > base) ok = 1'b1;
        end
        chk("accept", 64'(ok), 64'd1);
        if (!hold) req_valid = 1'b0;
        // Request fields must be ignored once captured.
        req_cmd1 = c1 ^ 8'h5A; req_addr = ~a; req_addr_cnt = 3'd2;
        req_cmd2_en = ~c2en; req_cmd2 = 8'hEE; req_wait_rb = ~wrb;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        bit ok;
        base = n_done;
        ok   = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            if (n_done > base) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_acts(input string tag, input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            if (act_kind.size() >= n) ok = 1'b1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] rp_data [0:6];
    bit         rp_kind [0:6];
    int         base_done;
    bit         seen;

    initial begin
        rp_data = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h30};
        rp_kind = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state.
        #2 nreset = 1'b0;
        tick(3);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_cmd_act", 64'(cmd_activate), 64'd0);
        chk("rst_addr_act", 64'(addr_activate), 64'd0);
        chk("rst_latch_data", 64'(latch_data), 64'd0);
        nreset = 1'b1;
        tick(2);
        chk("idle_ready", 64'(req_ready), 64'd1);

        // READ PAGE: 00h, five address bytes, 30h, then R/B# wait.
        lat = 2; nand_rb = 1'b0; clear_log();
        do_req(8'h00, 40'h0403020100, 3'd5, 1'b1, 8'h30, 1'b1, 1'b0);
        wait_acts("rp_acts_seen", 7, 200);
        base_done = n_done;
        tick(18);
        chk("rp_no_early_done", 64'(n_done), 64'(base_done));
        nand_rb = 1'b1;
        wait_done("rp_done", 20);
        chk("rp_timeout", 64'(done_to), 64'd0);
        chk("rp_act_count", 64'(act_kind.size()), 64'd7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("rp_act%0d", i), {47'd0, act_kind[i], act_data[i]}, {47'd0, rp_kind[i], 8'h00, rp_data[i]});
        // R/B# raised in cycle last_act+19, sampled at its end.
        chk("rp_done_cycle", 64'(done_cyc), 64'(act_cyc[6] + 20));

        // RESET command: single CLE latch, no wait.
        lat = 4; nand_rb = 1'b0; clear_log(); tick(2);
        do_req(8'hFF, 40'h0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_done("rst_cmd_done", 40);
        chk("rst_cmd_acts", 64'(act_kind.size()), 64'd1);
        chk("rst_cmd_data", 64'(act_data[0]), 64'h00FF);
        chk("rst_cmd_kind", 64'(act_kind[0]), 64'd0);
        chk("rst_cmd_latency", 64'(done_cyc - acc_cyc), 64'(lat + 3));
        chk("rst_cmd_timeout", 64'(done_to), 64'd0);

        // Status with R/B# already high: WAIT_WB runs its full length regardless.
        lat = 2; nand_rb = 1'b1; clear_log(); tick(2);
        do_req(8'h70, 40'h0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_done("st_done", 60);
        chk("st_done_cycle", 64'(done_cyc), 64'(act_cyc[0] + lat + 3 + TWB));
        chk("st_timeout", 64'(done_to), 64'd0);

        // Address count 7 clamps to 5.
        lat = 1; clear_log(); tick(2);
        do_req(8'h00, 40'hAABBCCDDEE, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_done("clamp_done", 80);
        chk("clamp_acts", 64'(act_kind.size()), 64'd6);
        chk("clamp_first_addr", {47'd0, act_kind[1], act_data[1]}, {47'd0, 1'b1, 16'h00EE});
        chk("clamp_last_addr", {47'd0, act_kind[5], act_data[5]}, {47'd0, 1'b1, 16'h00AA});
        chk("clamp_gap", 64'(act_cyc[2] - act_cyc[1]), 64'd3);

        // R/B# never rises: timeout after T_WB + RB_TIMEOUT from the last drain.
        lat = 3; nand_rb = 1'b0; clear_log(); tick(2);
        do_req(8'h00, 40'h5A, 3'd1, 1'b1, 8'h30, 1'b1, 1'b0);
        wait_done("to_done", 150);
        chk("to_timeout", 64'(done_to), 64'd1);
        chk("to_done_cycle", 64'(done_cyc), 64'(act_cyc[2] + lat + 2 + TWB + RBT));
        chk("to_acts", 64'(act_kind.size()), 64'd3);

        // Reset during the third address latch.
        lat = 8; nand_rb = 1'b1; clear_log(); tick(2);
        base_done = n_done;
        do_req(8'h00, 40'h0403020100, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_acts("mr_third_addr", 4, 100);
        nreset = 1'b0;
        #1;
        chk("mr_latch_data_async", 64'(latch_data), 64'd0);
        tick(2);
        chk("mr_ready_in_reset", 64'(req_ready), 64'd0);
        nreset = 1'b1;
        tick(1);
        chk("mr_ready_while_busy", 64'(req_ready), 64'd0);
        chk("mr_no_activate", 64'({cmd_activate, addr_activate}), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (!addr_busy) seen = 1'b1;
            else tick(1);
        end
        chk("mr_busy_drained", 64'(seen), 64'd1);
        chk("mr_ready_after_drain", 64'(req_ready), 64'd1);
        tick(3);
        chk("mr_no_done", 64'(n_done), 64'(base_done));
        lat = 2; clear_log();
        do_req(8'hFF, 40'h0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_done("mr_next_done", 40);
        chk("mr_next_data", 64'(act_data[0]), 64'h00FF);

        // Back-to-back with req_valid held high.
        lat = 2; clear_log(); tick(2);
        base_done = n_done;
        do_req(8'hFF, 40'h0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        req_cmd1 = 8'h90; req_addr = 40'h20; req_addr_cnt = 3'd1;
        req_cmd2_en = 1'b0; req_cmd2 = 8'h00; req_wait_rb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick(1);
            if (n_acc >= 2 && n_done > base_done) seen = (acc_cyc > done_cyc);
        end
        req_valid = 1'b0;
        chk("b2b_second_accept", 64'(seen), 64'd1);
        chk("b2b_accept_after_done", 64'(acc_cyc - done_cyc), 64'd1);
        wait_done("b2b_done2", 60);
        chk("b2b_acts", 64'(act_kind.size()), 64'd3);
        chk("b2b_act0", {47'd0, act_kind[0], act_data[0]}, {47'd0, 1'b0, 16'h00FF});
        chk("b2b_act1", {47'd0, act_kind[1], act_data[1]}, {47'd0, 1'b0, 16'h0090});
        chk("b2b_act2", {47'd0, act_kind[2], act_data[2]}, {47'd0, 1'b1, 16'h0020});

        tick(2);
        chk("protocol_violations", 64'(viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
